// File: rtl/ooo6502_pkg.sv
// Shared 6502 frontend types: fetch FSM states, queued instruction entry, and the
// NMOS opcode length/legality table.
package ooo6502_pkg;

  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'hFFFC;

  typedef enum logic [2:0] {VEC_LO, VEC_HI, OPCODE, OPND1, OPND2} fetch_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic        illegal;
  } insn_entry_t;

  // Returns {illegal, len}; decoded on the aaabbbcc opcode fields.
  function automatic logic [2:0] opcode_len(input logic [7:0] op);
    logic [2:0] a, b;
    logic       ill;
    logic [1:0] l;
    a   = op[7:5];
    b   = op[4:2];
    ill = 1'b0;
    l   = 2'd1;
    case (op[1:0])
      2'b01: begin
        l   = (b == 3'd3 || b == 3'd6 || b == 3'd7) ? 2'd3 : 2'd2;
        ill = (op == 8'h89);
      end
      2'b10: case (b)
        3'd0:       begin l = 2'd2; ill = (a != 3'd5); end
        3'd1, 3'd5: l = 2'd2;
        3'd2:       l = 2'd1;
        3'd3, 3'd7: begin l = 2'd3; ill = (op == 8'h9E); end
        3'd4:       ill = 1'b1;
        3'd6:       ill = !(a == 3'd4 || a == 3'd5);
      endcase
      2'b00: case (b)
        3'd0: case (a)
          3'd0:       l = 2'd2;
          3'd1:       l = 2'd3;
          3'd2, 3'd3: l = 2'd1;
          3'd4:       ill = 1'b1;
          default:    l = 2'd2;
        endcase
        3'd1:       begin l = 2'd2; ill = (a == 3'd0 || a == 3'd2 || a == 3'd3); end
        3'd2, 3'd6: l = 2'd1;
        3'd3:       begin l = 2'd3; ill = (a == 3'd0); end
        3'd4:       l = 2'd2;
        3'd5:       begin l = 2'd2; ill = !(a == 3'd4 || a == 3'd5); end
        3'd7:       begin l = 2'd3; ill = (a != 3'd5); end
      endcase
      default: ill = 1'b1;
    endcase
    if (ill) l = 2'd1;
    return {ill, l};
  endfunction

endpackage

// File: rtl/insn_queue.sv
// Synchronous FIFO of assembled instructions; flush empties it in one cycle.
module insn_queue import ooo6502_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  insn_entry_t push_data,
  input  logic        pop,
  output insn_entry_t head,
  output logic        head_vld,
  output logic [CW-1:0] count
);

  insn_entry_t    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head     = mem[rd_ptr];
  assign head_vld = (count != '0);

endmodule

// File: rtl/fetch_assembler.sv
// 6502 fetch stage: loads the reset vector, fetches bytes one at a time and assembles
// 1-3 byte instructions into insn_queue; redirect restarts fetch at a new PC.
module fetch_assembler import ooo6502_pkg::*; #(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          QUEUE_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        bus_gnt,
  input  logic [7:0]  data_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [15:0] insn_pc,
  output logic [7:0]  insn_opcode,
  output logic [15:0] insn_operand,
  output logic [1:0]  insn_len,
  output logic        insn_illegal
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  state, nstate;
  logic [15:0]   pc, op_pc;
  logic [7:0]    opcode, opnd_lo;
  logic [1:0]    len, nlen, dlen;
  logic          illegal, dill, armed, inflight;
  logic          rvld, acc, push, pop, completes, is_vec;
  logic [CW-1:0] count, occ_next;
  insn_entry_t   push_entry, head;

  // Data returns one cycle after an accepted request; inflight marks that cycle.
  assign rvld = inflight;
  assign is_vec = (state == VEC_LO) || (state == VEC_HI);

  always_comb begin
    nstate = state;
    nlen   = len;
    {dill, dlen} = opcode_len(data_in);
    push_entry = '{pc: op_pc, opcode: opcode, operand: 16'h0, len: len, illegal: illegal};
    if (rvld) begin
      case (state)
        VEC_LO: nstate = VEC_HI;
        VEC_HI: nstate = OPCODE;
        OPCODE: begin
          nlen   = dlen;
          nstate = (dlen == 2'd1) ? OPCODE : OPND1;
          push_entry.opcode  = data_in;
          push_entry.len     = dlen;
          push_entry.illegal = dill;
        end
        OPND1: begin
          nstate = (len == 2'd2) ? OPCODE : OPND2;
          push_entry.operand = {8'h00, data_in};
        end
        OPND2: begin
          nstate = OPCODE;
          push_entry.operand = {data_in, opnd_lo};
        end
        default: ;
      endcase
    end
  end

  assign push = rvld && !is_vec && (nstate == OPCODE);
  assign pop  = insn_valid && insn_ready;

  // An opcode fetch may turn out to be 1 byte, so it is treated as completing.
  assign completes = (nstate == OPCODE) || (nstate == OPND2) ||
                     (nstate == OPND1 && nlen == 2'd2);
  assign occ_next  = count + CW'(push) - CW'(pop);

  assign fetch_req = armed && (is_vec ? !inflight
                                      : !(completes && occ_next == CW'(QUEUE_DEPTH)));
  assign acc = fetch_req && bus_gnt;

  always_comb begin
    if (!armed)               fetch_addr = 16'h0000;
    else if (state == VEC_LO) fetch_addr = RESET_VECTOR;
    else if (state == VEC_HI) fetch_addr = RESET_VECTOR + 16'd1;
    else                      fetch_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= VEC_LO;
      pc       <= 16'h0;
      op_pc    <= 16'h0;
      opcode   <= 8'h0;
      opnd_lo  <= 8'h0;
      len      <= 2'd0;
      illegal  <= 1'b0;
      armed    <= 1'b0;
      inflight <= 1'b0;
    end else if (redirect) begin
      state    <= OPCODE;
      pc       <= redirect_pc;
      armed    <= 1'b1;
      inflight <= 1'b0;
    end else begin
      armed    <= 1'b1;
      inflight <= acc;
      state    <= nstate;
      len      <= nlen;
      if (rvld) begin
        case (state)
          VEC_LO: pc[7:0]  <= data_in;
          VEC_HI: pc[15:8] <= data_in;
          OPCODE: begin opcode <= data_in; illegal <= dill; end
          OPND1:  opnd_lo <= data_in;
          default: ;
        endcase
      end
      if (acc && !is_vec) begin
        pc <= pc + 16'd1;
        if (nstate == OPCODE) op_pc <= pc;
      end
    end
  end

  insn_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .head_vld  (insn_valid),
    .count     (count)
  );

  assign insn_pc      = head.pc;
  assign insn_opcode  = head.opcode;
  assign insn_operand = head.operand;
  assign insn_len     = head.len;
  assign insn_illegal = head.illegal;

endmodule

// File: tb/tb_fetch_assembler.sv
// Scoreboard bench: expected entries are queued by the stimulus; a negedge monitor
// pops and compares whenever the DUT hands an instruction to the frontend.
module tb_fetch_assembler;
  import ooo6502_pkg::*;

  logic        clk, rst;
  logic        fetch_req, bus_gnt, redirect, insn_valid, insn_ready, insn_illegal;
  logic [15:0] fetch_addr, redirect_pc, insn_pc, insn_operand;
  logic [7:0]  data_in, insn_opcode;
  logic [1:0]  insn_len;

  logic [7:0]  mem [65536];
  logic [15:0] acc_log [$];
  insn_entry_t sb [$];
  logic        gnt_en, stab_en;
  logic [15:0] stop_addr;
  int          vectors = 0, errors = 0;
  int          cyc = 0, t8003 = 0, lat8003 = -1;

  fetch_assembler #(.RESET_VECTOR(16'hFFFC), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .bus_gnt(bus_gnt), .data_in(data_in), .redirect(redirect), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_pc(insn_pc),
    .insn_opcode(insn_opcode), .insn_operand(insn_operand), .insn_len(insn_len),
    .insn_illegal(insn_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter withholds grant at stop_addr so each phase parks at a known address.
  assign bus_gnt = gnt_en && (fetch_addr != stop_addr);

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fetch_req === 1'b1 && bus_gnt === 1'b1) begin
      data_in <= mem[fetch_addr];
      acc_log.push_back(fetch_addr);
      if (fetch_addr == 16'h8003) t8003 <= cyc;
    end else begin
      data_in <= 8'h5A;
    end
  end

  function automatic insn_entry_t mk(input logic [15:0] p, input logic [7:0] op,
                                     input logic [15:0] od, input logic [1:0] l,
                                     input logic ill);
    mk = '{pc: p, opcode: op, operand: od, len: l, illegal: ill};
  endfunction

  // Monitor: scoreboard pops plus fetch_addr stability while ungranted.
  initial begin
    insn_entry_t got, exp;
    logic        prev_pend, prev_redir;
    logic [15:0] prev_addr;
    prev_pend = 1'b0; prev_redir = 1'b0; prev_addr = 16'h0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (insn_valid && insn_ready) begin
          got = '{pc: insn_pc, opcode: insn_opcode, operand: insn_operand,
                  len: insn_len, illegal: insn_illegal};
          vectors++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_entry got pc=%h op=%h opnd=%h len=%0d ill=%0d required none",
                     got.pc, got.opcode, got.operand, got.len, got.illegal);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL entry got pc=%h op=%h opnd=%h len=%0d ill=%0d required pc=%h op=%h opnd=%h len=%0d ill=%0d",
                       got.pc, got.opcode, got.operand, got.len, got.illegal,
                       exp.pc, exp.opcode, exp.operand, exp.len, exp.illegal);
            end
            if (got.pc == 16'h8003 && got.opcode == 8'h8D) lat8003 = cyc - t8003;
          end
        end
        if (stab_en && prev_pend && !prev_redir && fetch_req) begin
          vectors++;
          if (fetch_addr !== prev_addr) begin
            errors++;
            $display("FAIL addr_stable got %h required %h", fetch_addr, prev_addr);
          end
        end
        prev_pend  = fetch_req && !bus_gnt;
        prev_addr  = fetch_addr;
        prev_redir = redirect;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, exp);
    end
  endtask

  task automatic chk_acc(input string nm, input int base, input int idx, input logic [15:0] exp);
    logic [31:0] got;
    got = (base + idx < acc_log.size()) ? {16'h0, acc_log[base + idx]} : 32'hDEAD0000;
    chk(nm, got, {16'h0, exp});
  endtask

  // Waits until fetch is parked at a, the queue is drained and the scoreboard is empty.
  task automatic wait_idle(input logic [15:0] a, input bit tog, input string nm);
    int n;
    for (n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (tog) gnt_en = ~gnt_en;
      if (fetch_req && fetch_addr == a && !insn_valid && sb.size() == 0) break;
    end
    chk({nm, "_idle_timeout"}, 32'(n >= 400), 32'd0);
  endtask

  task automatic do_redirect(input logic [15:0] a, input logic [15:0] stop);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = a; stop_addr = stop;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b0; gnt_en = 1'b1; stab_en = 1'b0; stop_addr = 16'h8006;
    insn_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h42;
    mem[16'h8003] = 8'h8D; mem[16'h8004] = 8'h00; mem[16'h8005] = 8'h02;
    mem[16'h8011] = 8'hA5; mem[16'h8012] = 8'h33;
    mem[16'h9000] = 8'hE8; mem[16'h9001] = 8'hA2; mem[16'h9002] = 8'h07;
    begin
      logic [7:0] prog [41];
      prog = '{8'hA9,8'h10, 8'h85,8'h20, 8'hAD,8'h34,8'h12, 8'hE8, 8'h9D,8'h00,8'h03,
               8'hD0,8'hFE, 8'h20,8'h00,8'hB0, 8'h60, 8'h00,8'h55, 8'h40, 8'hB1,8'h44,
               8'h6C,8'hFE,8'h12, 8'h0A, 8'h96,8'h80, 8'hBE,8'h01,8'h02, 8'h9A,
               8'hC0,8'h05, 8'hBC,8'h11,8'h22, 8'h48, 8'h2C,8'h77,8'h66};
      for (int i = 0; i < 41; i++) mem[16'hA000 + 16'(i)] = prog[i];
    end
    mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h02;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_fetch_addr", 32'(fetch_addr), 32'd0);
    chk("rst_insn_valid", 32'(insn_valid), 32'd0);
    chk("rst_pc_op", {insn_pc, insn_opcode, 8'h0}, 32'd0);
    chk("rst_opnd_len_ill", {insn_operand, 13'd0, insn_len, insn_illegal}, 32'd0);

    // Vector load and first instructions
    sb.push_back(mk(16'h8000, 8'hEA, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'h8001, 8'hA9, 16'h0042, 2'd2, 1'b0));
    sb.push_back(mk(16'h8003, 8'h8D, 16'h0200, 2'd3, 1'b0));
    @(posedge clk); #1 rst = 1'b1;
    wait_idle(16'h8006, 1'b0, "stream");
    chk_acc("vec_lo_addr", 0, 0, 16'hFFFC);
    chk_acc("vec_hi_addr", 0, 1, 16'hFFFD);
    chk_acc("first_opcode_addr", 0, 2, 16'h8000);
    chk("len3_latency", 32'(lat8003), 32'd4);

    // Backpressure: queue fills to depth and fetch stops
    insn_ready = 1'b0;
    for (int i = 6; i < 16; i++) sb.push_back(mk(16'h8000 + 16'(i), 8'hEA, 16'h0, 2'd1, 1'b0));
    base = acc_log.size();
    stop_addr = 16'h8010;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_accepts", 32'(acc_log.size() - base), 32'd4);
    chk("full_fetch_req", 32'(fetch_req), 32'd0);
    chk("full_insn_valid", 32'(insn_valid), 32'd1);
    @(posedge clk); #1 insn_ready = 1'b1;
    wait_idle(16'h8010, 1'b0, "drain");
    chk("drain_accepts", 32'(acc_log.size() - base), 32'd10);

    // Redirect while the OPND1 byte of A5 33 is returning
    @(posedge clk); #1;
    insn_ready = 1'b0; stop_addr = 16'h8013;
    for (n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (acc_log.size() > 0 && acc_log[$] == 16'h8012) break;
    end
    chk("opnd1_issue_timeout", 32'(n >= 50), 32'd0);
    redirect = 1'b1; redirect_pc = 16'h9000;
    @(posedge clk); #1;
    redirect = 1'b0; stop_addr = 16'h9003;
    base = acc_log.size();
    @(negedge clk);
    chk("redirect_flush_valid", 32'(insn_valid), 32'd0);
    sb.push_back(mk(16'h9000, 8'hE8, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'h9001, 8'hA2, 16'h0007, 2'd2, 1'b0));
    @(posedge clk); #1 insn_ready = 1'b1;
    wait_idle(16'h9003, 1'b0, "redirect");
    chk_acc("redirect_first_addr", base, 0, 16'h9000);
    chk("redirect_accepts", 32'(acc_log.size() - base), 32'd3);

    // Toggling grant over 20 mixed-length instructions
    sb.push_back(mk(16'hA000, 8'hA9, 16'h0010, 2'd2, 1'b0));
    sb.push_back(mk(16'hA002, 8'h85, 16'h0020, 2'd2, 1'b0));
    sb.push_back(mk(16'hA004, 8'hAD, 16'h1234, 2'd3, 1'b0));
    sb.push_back(mk(16'hA007, 8'hE8, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'hA008, 8'h9D, 16'h0300, 2'd3, 1'b0));
    sb.push_back(mk(16'hA00B, 8'hD0, 16'h00FE, 2'd2, 1'b0));
    sb.push_back(mk(16'hA00D, 8'h20, 16'hB000, 2'd3, 1'b0));
    sb.push_back(mk(16'hA010, 8'h60, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'hA011, 8'h00, 16'h0055, 2'd2, 1'b0));
    sb.push_back(mk(16'hA013, 8'h40, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'hA014, 8'hB1, 16'h0044, 2'd2, 1'b0));
    sb.push_back(mk(16'hA016, 8'h6C, 16'h12FE, 2'd3, 1'b0));
    sb.push_back(mk(16'hA019, 8'h0A, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'hA01A, 8'h96, 16'h0080, 2'd2, 1'b0));
    sb.push_back(mk(16'hA01C, 8'hBE, 16'h0201, 2'd3, 1'b0));
    sb.push_back(mk(16'hA01F, 8'h9A, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'hA020, 8'hC0, 16'h0005, 2'd2, 1'b0));
    sb.push_back(mk(16'hA022, 8'hBC, 16'h2211, 2'd3, 1'b0));
    sb.push_back(mk(16'hA025, 8'h48, 16'h0000, 2'd1, 1'b0));
    sb.push_back(mk(16'hA026, 8'h2C, 16'h6677, 2'd3, 1'b0));
    do_redirect(16'hA000, 16'hA029);
    stab_en = 1'b1;
    wait_idle(16'hA029, 1'b1, "toggle_grant");
    stab_en = 1'b0; gnt_en = 1'b1;

    // PC wrap at FFFF and an undocumented opcode
    sb.push_back(mk(16'hFFFF, 8'h4C, 16'h1234, 2'd3, 1'b0));
    sb.push_back(mk(16'h0002, 8'h02, 16'h0000, 2'd1, 1'b1));
    do_redirect(16'hFFFF, 16'h0003);
    base = acc_log.size();
    wait_idle(16'h0003, 1'b0, "wrap");
    chk_acc("wrap_addr0", base, 0, 16'hFFFF);
    chk_acc("wrap_addr1", base, 1, 16'h0000);
    chk_acc("wrap_addr2", base, 2, 16'h0001);
    chk_acc("wrap_addr3", base, 3, 16'h0002);

    repeat (4) @(posedge clk);
    chk("scoreboard_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
